// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-port signals of mem_port_arbiter
interface mem_port_arbiter_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_write;
  logic [1:0]  d_width;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_req;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_write;
  logic [1:0]  m_width;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_write, d_width,
           m_ready, m_rvalid, m_rdata,
    output i_ready, i_rvalid, i_rdata, i_err, d_ready, d_rvalid, d_rdata, d_err,
           m_req, m_addr, m_wdata, m_write, m_width
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_write, d_width,
           m_ready, m_rvalid, m_rdata,
    input  i_ready, i_rvalid, i_rdata, i_err, d_ready, d_rvalid, d_rdata, d_err,
           m_req, m_addr, m_wdata, m_write, m_width
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/load-store arbiter for one memory port
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;    // last_grant: 1 = D, 0 = I
  logic        owner_d_q, owner_d_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  width_q, width_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic        i_err_q, i_err_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        grant_i, grant_d, i_ready, d_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  always_comb begin
    grant_d    = bus.d_valid & (~bus.i_valid | ~last_d_q);
    grant_i    = bus.i_valid & ~grant_d;
    // real data wins over a timeout landing on the same cycle
    resp_data  = bus.m_rvalid ? bus.m_rdata : ERR_DATA;
    resp_err   = ~bus.m_rvalid;
    state_d    = state_q;
    last_d_d   = last_d_q;
    owner_d_d  = owner_d_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    width_d    = width_q;
    cnt_d      = cnt_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_err_d    = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        i_ready = grant_i;
        d_ready = grant_d;
        if (grant_i | grant_d) begin
          owner_d_d = grant_d;
          last_d_d  = grant_d;
          addr_d    = grant_d ? bus.d_addr : bus.i_addr;
          wdata_d   = grant_d ? bus.d_wdata : 32'd0;
          write_d   = grant_d & bus.d_write;
          width_d   = grant_d ? bus.d_width : 2'b10;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.m_ready) begin
          if (write_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = 32'd0;
            state_d    = S_IDLE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.m_rvalid || cnt_q == CNT_LAST) begin
          if (owner_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = resp_data;
            d_err_d    = resp_err;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = resp_data;
            i_err_d    = resp_err;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_d_q   <= 1'b0;
      owner_d_q  <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      write_q    <= 1'b0;
      width_q    <= 2'b10;
      cnt_q      <= 8'd0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      owner_d_q  <= owner_d_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      width_q    <= width_d;
      cnt_q      <= cnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_ready  = i_ready;
  assign bus.d_ready  = d_ready;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_err    = i_err_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign bus.m_req    = (state_q == S_ISSUE);
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.m_write  = write_q;
  assign bus.m_width  = width_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (read-only requester I) and the execute stage's load/store path (requester D).
- Uses round-robin arbitration and allows one outstanding transaction at a time.
- Drives a request/accept memory interface and routes the read response back to the requester that owns the transaction.
- A WAIT-state timeout stops a stalled memory from hanging the pipeline.

Parameters:
- TIMEOUT, 64: maximum cycles in WAIT before an error response is forced; legal range 2..255.
- ERR_DATA, 32'hDEADBEEF: read data returned with an error response.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- i_valid  in  1  fetch read request.
- i_ready  out  1  fetch request accepted this cycle.
- i_addr  in  32  fetch address.
- i_rvalid  out  1  fetch response, one-cycle pulse.
- i_rdata  out  32  fetch read data.
- i_err  out  1  fetch response is a timeout error.
- d_valid  in  1  load/store request.
- d_ready  out  1  load/store request accepted this cycle.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_write  in  1  1=store, 0=load.
- d_width  in  2  access width (funct3[1:0] encoding); passed through unchanged.
- d_rvalid  out  1  load response or store completion, one-cycle pulse.
- d_rdata  out  32  load data; 0 on store completion.
- d_err  out  1  load response is a timeout error.
- m_req  out  1  memory request.
- m_ready  in  1  memory accepts the request.
- m_addr  out  32  latched address.
- m_wdata  out  32  latched store data.
- m_write  out  1  latched write flag.
- m_width  out  2  latched width; 2'b10 for fetch.
- m_rvalid  in  1  memory read data valid.
- m_rdata  in  32  memory read data.

Behaviour:
- Reset values: state=IDLE; last_grant=I (so D wins the first contention); every output 0 except m_width=2'b10; timeout counter=0.
- A reset mid-transaction drops the transaction: no response is issued, and any late m_rvalid after reset is ignored because the state is IDLE.
- States:
  - IDLE: grant computed combinationally. Single requester wins. Both requesting: the port not equal to last_grant wins. i_ready = IDLE & grant_I; d_ready = IDLE & grant_D. Both are combinational, and at most one is high per cycle. On acceptance, latch addr/wdata/write/width and owner, set last_grant=owner, go to ISSUE.
  - ISSUE: m_req=1 with the latched fields held stable until m_ready.
    - m_ready and write: next cycle d_rvalid=1, d_rdata=0, d_err=0; state goes to IDLE.
    - m_ready and read: go to WAIT, counter cleared.
    - No timeout in ISSUE.
  - WAIT: m_req=0; counter increments each cycle.
    - m_rvalid: next cycle owner's rvalid=1, rdata=m_rdata, err=0; state goes to IDLE.
    - Counter reaches TIMEOUT-1 without m_rvalid: next cycle owner's rvalid=1, rdata=ERR_DATA, err=1; state goes to IDLE.
    - m_rvalid on that same cycle: real data wins and err=0.
    - m_rvalid seen in IDLE or ISSUE is ignored.
- Response outputs are registered, and rvalid is high for exactly one cycle.
- State is IDLE in the response cycle, so a new request can be accepted that same cycle (back-to-back).
- Latency with zero-wait memory: accept at T, m_req at T+1, m_rvalid at T+2, rvalid at T+3.
- Requesters hold valid and fields stable until ready. A requester that drops valid before ready is simply not granted.
- last_grant updates only on acceptance.
- i_rdata/d_rdata hold their value between pulses; only the owner's rvalid pulses.
- m_width for fetch is forced to 2'b10.

Test Plan:
- Reset held low 2 cycles, then released, no requests → all outputs 0, m_width=2'b10, i_ready=d_ready=0.
- Fetch only, i_addr=0x100, memory m_ready at T+1, m_rvalid with 0x00000013 at T+2 → i_ready at T, m_req/m_addr=0x100 at T+1, i_rvalid=1, i_rdata=0x13, i_err=0 at T+3, d_rvalid stays 0.
- i_valid and d_valid high together for 4 transactions → grant order D, I, D, I; i_ready and d_ready never high together.
- Store d_addr=0x200, d_wdata=0xCAFEF00D, d_width=2'b00, m_ready delayed 3 cycles → m_req held 3 cycles with fields stable, m_write=1, d_rvalid pulse one cycle after m_ready, d_rdata=0.
- Load with TIMEOUT=4 and no m_rvalid → d_rvalid=1, d_err=1, d_rdata=0xDEADBEEF five cycles after m_ready; next request then accepted normally.
- rst driven low while in WAIT, then m_rvalid arrives after rst released → no rvalid on either port, state IDLE, next request served normally.
